switch_debouncer: RTL and testbench

//  Conditions the 16 raw Basys 3 slide switches before they reach the switches bus interface
//  (CPU addresses 0xC2 = SW[7:0], 0xC3 = SW[15:8]).

---
 rtl/switch_debouncer_pkg.sv | 16 +
 rtl/switch_debounce_bit.sv | 62 ++++++
 rtl/switch_debouncer.sv | 67 ++++++
 tb/tb_switch_debouncer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_debouncer_pkg.sv
// rtl/switch_debouncer_pkg.sv - shared defaults for the slide-switch debouncer
// Purpose: default sizing for switch_debouncer and switch_debounce_bit, plus the
//          per-bit counter width helper.
// Ports:   none (package)
package switch_debouncer_pkg;

   localparam int SW_NUM_DEFAULT       = 16;
   localparam int TICK_DIV_DEFAULT     = 100000;
   localparam int STABLE_TICKS_DEFAULT = 10;

   // Counter must hold 0..STABLE_TICKS-1; sized as $clog2(STABLE_TICKS+1).
   function automatic int cnt_width(input int stable_ticks);
      return (stable_ticks < 1) ? 1 : $clog2(stable_ticks + 1);
   endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// rtl/switch_debounce_bit.sv - one switch bit: 2-flop synchroniser, tick counter, output flop
// Purpose: accepts a new level only after STABLE_TICKS consecutive sample ticks of mismatch.
// Ports:   CLK, RESETn   clock, asynchronous active-low reset
//          raw           raw switch pin (asynchronous)
//          tick          1-cycle sample strobe from the shared prescaler
//          level         debounced level
//          rise, fall    registered 1-cycle strobes on an accepted 0->1 / 1->0
//          accept        high in the cycle before level changes (feeds the any-change flop)
module switch_debounce_bit
   import switch_debouncer_pkg::*;
#(
   parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT
) (
   input  logic CLK,
   input  logic RESETn,
   input  logic raw,
   input  logic tick,
   output logic level,
   output logic rise,
   output logic fall,
   output logic accept
);

   localparam int              CW       = cnt_width(STABLE_TICKS);
   localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_TICKS - 1);

   logic          sync_meta;
   logic          sync;
   logic [CW-1:0] cnt;

   assign accept = (sync != level) && tick && (cnt == CNT_LAST);

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         sync_meta <= 1'b0;
         sync      <= 1'b0;
         cnt       <= '0;
         level     <= 1'b0;
         rise      <= 1'b0;
         fall      <= 1'b0;
      end else begin
         sync_meta <= raw;
         sync      <= sync_meta;
         rise      <= 1'b0;
         fall      <= 1'b0;
         if (sync == level) begin
            // Any return to the current level restarts the count, tick or not.
            cnt <= '0;
         end else if (tick) begin
            if (accept) begin
               level <= sync;
               cnt   <= '0;
               rise  <= sync;
               fall  <= ~sync;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - debounced slide-switch vector with edge strobes
// Purpose: synchronises and debounces NUM_SW raw switches for the switches bus interface.
// Ports:   CLK, RESETn   clock, asynchronous active-low reset
//          SW_IN         raw switch pins (asynchronous)
//          SW_OUT        debounced levels; only change on an accept edge
//          SW_RISE       per-bit 1-cycle strobe on accepted 0->1
//          SW_FALL       per-bit 1-cycle strobe on accepted 1->0
//          SW_CHANGED    1-cycle strobe when any SW_OUT bit changes
module switch_debouncer
   import switch_debouncer_pkg::*;
#(
   parameter int NUM_SW       = SW_NUM_DEFAULT,
   parameter int TICK_DIV     = TICK_DIV_DEFAULT,
   parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT
) (
   input  logic              CLK,
   input  logic              RESETn,
   input  logic [NUM_SW-1:0] SW_IN,
   output logic [NUM_SW-1:0] SW_OUT,
   output logic [NUM_SW-1:0] SW_RISE,
   output logic [NUM_SW-1:0] SW_FALL,
   output logic              SW_CHANGED
);

   localparam int            PW         = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0]     presc;
   logic              tick;
   logic [NUM_SW-1:0] accept;

   // Shared prescaler; tick is registered so it is high for one cycle per wrap.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         presc <= '0;
         tick  <= 1'b0;
      end else begin
         presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
         tick  <= (presc == PRESC_LAST);
      end
   end

   for (genvar i = 0; i < NUM_SW; i++) begin : g_bits
      switch_debounce_bit #(
         .STABLE_TICKS (STABLE_TICKS)
      ) u_bit (
         .CLK    (CLK),
         .RESETn (RESETn),
         .raw    (SW_IN[i]),
         .tick   (tick),
         .level  (SW_OUT[i]),
         .rise   (SW_RISE[i]),
         .fall   (SW_FALL[i]),
         .accept (accept[i])
      );
   end

   // Registered from the pre-edge accept terms so it lines up with SW_RISE/SW_FALL.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         SW_CHANGED <= 1'b0;
      end else begin
         SW_CHANGED <= |accept;
      end
   end

endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - self-checking bench for switch_debouncer
module tb_switch_debouncer;

   localparam int NSW = 16;
   localparam int TD  = 4;
   localparam int ST  = 3;

   logic           CLK = 1'b0;
   logic           RESETn = 1'b0;
   logic [NSW-1:0] SW_IN = '0;
   logic [NSW-1:0] SW_OUT;
   logic [NSW-1:0] SW_RISE;
   logic [NSW-1:0] SW_FALL;
   logic           SW_CHANGED;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   switch_debouncer #(
      .NUM_SW       (NSW),
      .TICK_DIV     (TD),
      .STABLE_TICKS (ST)
   ) dut (
      .CLK        (CLK),
      .RESETn     (RESETn),
      .SW_IN      (SW_IN),
      .SW_OUT     (SW_OUT),
      .SW_RISE    (SW_RISE),
      .SW_FALL    (SW_FALL),
      .SW_CHANGED (SW_CHANGED)
   );

   // Reference model: deadline based. When a bit's synchronised value first differs
   // from its output, the accept edge is the ST-th sample tick from that edge on;
   // any matching edge before then cancels the deadline.
   int             n_edge;
   logic [NSW-1:0] h1, h2;
   logic [NSW-1:0] m_out, m_rise, m_fall;
   logic           m_chg;
   int             dl [NSW];

   // Ticks are seen at edges TD+1, 2*TD+1, ... after reset release.
   function automatic int first_tick(input int k);
      if (k <= TD + 1) return TD + 1;
      return k + ((TD - ((k - 1) % TD)) % TD);
   endfunction

   function automatic int eff_dl(input int i);
      if (dl[i] != 0) return dl[i];
      return first_tick(n_edge + 1) + (ST - 1) * TD;
   endfunction

   function automatic logic due(input int i);
      return (h2[i] != m_out[i]) && (eff_dl(i) == n_edge + 1);
   endfunction

   function automatic logic any_due();
      logic r;
      r = 1'b0;
      for (int i = 0; i < NSW; i++) r = r | due(i);
      return r;
   endfunction

   always @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         n_edge <= 0;
         h1     <= '0;
         h2     <= '0;
         m_out  <= '0;
         m_rise <= '0;
         m_fall <= '0;
         m_chg  <= 1'b0;
         for (int i = 0; i < NSW; i++) dl[i] <= 0;
      end else begin
         n_edge <= n_edge + 1;
         h1     <= SW_IN;
         h2     <= h1;
         m_chg  <= any_due();
         for (int i = 0; i < NSW; i++) begin
            m_rise[i] <= 1'b0;
            m_fall[i] <= 1'b0;
            if (h2[i] == m_out[i]) begin
               dl[i] <= 0;
            end else if (due(i)) begin
               m_out[i]  <= h2[i];
               dl[i]     <= 0;
               m_rise[i] <= h2[i];
               m_fall[i] <= ~h2[i];
            end else begin
               dl[i] <= eff_dl(i);
            end
         end
      end
   end

   task automatic test_reset();
      int first = -1;
      int n_chg = 0;
      int n_rise = 0;
      RESETn = 1'b0;
      SW_IN  = '1;
      repeat (3) @(negedge CLK);
      checks++;
      if ({SW_OUT, SW_RISE, SW_FALL, SW_CHANGED} !== '0) begin
         errors++;
         $display("FAIL reset_state: got out=%h rise=%h fall=%h chg=%b, expected all 0",
                  SW_OUT, SW_RISE, SW_FALL, SW_CHANGED);
      end
      RESETn = 1'b1;
      for (int j = 1; j <= 20; j++) begin
         @(negedge CLK);
         checks++;
         if ({SW_OUT, SW_RISE, SW_FALL, SW_CHANGED} !== {m_out, m_rise, m_fall, m_chg}) begin
            errors++;
            $display("FAIL reset_release_model: got out=%h rise=%h fall=%h chg=%b, expected out=%h rise=%h fall=%h chg=%b",
                     SW_OUT, SW_RISE, SW_FALL, SW_CHANGED, m_out, m_rise, m_fall, m_chg);
         end
         if (first < 0 && SW_OUT == 16'hFFFF) first = j;
         if (SW_CHANGED) n_chg++;
         if (SW_RISE == 16'hFFFF) n_rise++;
      end
      checks++;
      if (first < 1 || first > 14) begin
         errors++;
         $display("FAIL reset_release_latency: got %0d edges, expected 1..14", first);
      end
      checks++;
      if (n_chg != 1 || n_rise != 1) begin
         errors++;
         $display("FAIL reset_release_strobes: got chg=%0d rise=%0d cycles, expected 1 and 1", n_chg, n_rise);
      end
   endtask

   task automatic test_clean_step();
      int rise_at = -1;
      logic fall_seen = 1'b0;
      SW_IN = '0;
      repeat (30) begin
         @(negedge CLK);
         checks++;
         if ({SW_OUT, SW_RISE, SW_FALL, SW_CHANGED} !== {m_out, m_rise, m_fall, m_chg}) begin
            errors++;
            $display("FAIL clean_settle_model: got out=%h rise=%h fall=%h chg=%b, expected out=%h rise=%h fall=%h chg=%b",
                     SW_OUT, SW_RISE, SW_FALL, SW_CHANGED, m_out, m_rise, m_fall, m_chg);
         end
      end
      SW_IN[0] = 1'b1;
      for (int j = 1; j <= 20; j++) begin
         @(negedge CLK);
         checks++;
         if ({SW_OUT, SW_RISE, SW_FALL, SW_CHANGED} !== {m_out, m_rise, m_fall, m_chg}) begin
            errors++;
            $display("FAIL clean_step_model: got out=%h rise=%h fall=%h chg=%b, expected out=%h rise=%h fall=%h chg=%b",
                     SW_OUT, SW_RISE, SW_FALL, SW_CHANGED, m_out, m_rise, m_fall, m_chg);
         end
         if (SW_FALL != '0) fall_seen = 1'b1;
         if (rise_at < 0 && SW_OUT[0]) begin
            rise_at = j;
            checks++;
            if (SW_RISE !== 16'h0001) begin
               errors++;
               $display("FAIL clean_step_rise: got %h, expected 0001", SW_RISE);
            end
         end
      end
      checks++;
      if (rise_at - 1 < 10 || rise_at - 1 > 13) begin
         errors++;
         $display("FAIL clean_step_latency: got %0d edges, expected 10..13", rise_at - 1);
      end
      checks++;
      if (fall_seen) begin
         errors++;
         $display("FAIL clean_step_fall: got a fall strobe, expected none");
      end
   endtask

   task automatic test_bounce();
      logic bad = 1'b0;
      int   rise_at = -1;
      for (int c = 0; c < 40; c++) begin
         if (c % 3 == 0) SW_IN[3] = ~SW_IN[3];
         @(negedge CLK);
         checks++;
         if ({SW_OUT, SW_RISE, SW_FALL, SW_CHANGED} !== {m_out, m_rise, m_fall, m_chg}) begin
            errors++;
            $display("FAIL bounce_model: got out=%h rise=%h fall=%h chg=%b, expected out=%h rise=%h fall=%h chg=%b",
                     SW_OUT, SW_RISE, SW_FALL, SW_CHANGED, m_out, m_rise, m_fall, m_chg);
         end
         if (SW_OUT[3] || SW_RISE != '0 || SW_FALL != '0 || SW_CHANGED) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL bounce_quiet: got output/strobe activity while bouncing, expected none");
      end
      SW_IN[3] = 1'b1;
      for (int j = 1; j <= 20; j++) begin
         @(negedge CLK);
         if (rise_at < 0 && SW_OUT[3]) rise_at = j;
      end
      checks++;
      if (rise_at - 1 < 10 || rise_at - 1 > 13) begin
         errors++;
         $display("FAIL bounce_settle_latency: got %0d edges, expected 10..13", rise_at - 1);
      end
   endtask

   task automatic test_simultaneous();
      int   n_chg = 0;
      logic torn = 1'b0;
      SW_IN = 16'h00FF;
      repeat (25) @(negedge CLK);
      checks++;
      if (SW_OUT !== 16'h00FF) begin
         errors++;
         $display("FAIL simul_setup: got %h, expected 00FF", SW_OUT);
      end
      SW_IN = 16'hFF00;
      for (int j = 1; j <= 20; j++) begin
         @(negedge CLK);
         checks++;
         if ({SW_OUT, SW_RISE, SW_FALL, SW_CHANGED} !== {m_out, m_rise, m_fall, m_chg}) begin
            errors++;
            $display("FAIL simul_model: got out=%h rise=%h fall=%h chg=%b, expected out=%h rise=%h fall=%h chg=%b",
                     SW_OUT, SW_RISE, SW_FALL, SW_CHANGED, m_out, m_rise, m_fall, m_chg);
         end
         if (SW_OUT != 16'h00FF && SW_OUT != 16'hFF00) torn = 1'b1;
         if (SW_CHANGED) begin
            n_chg++;
            checks++;
            if ({SW_OUT, SW_RISE, SW_FALL} !== {16'hFF00, 16'hFF00, 16'h00FF}) begin
               errors++;
               $display("FAIL simul_edge: got out=%h rise=%h fall=%h, expected FF00 FF00 00FF",
                        SW_OUT, SW_RISE, SW_FALL);
            end
         end
      end
      checks++;
      if (n_chg != 1 || torn) begin
         errors++;
         $display("FAIL simul_single_pulse: got %0d pulses torn=%b, expected 1 pulse torn=0", n_chg, torn);
      end
   endtask

   task automatic test_reset_mid_count();
      int   guard = 0;
      int   first = -1;
      logic early = 1'b0;
      SW_IN = 16'hFF20;
      @(negedge CLK);
      while (!(dl[5] != 0 && n_edge >= dl[5] - TD) && guard < 40) begin
         @(negedge CLK);
         guard++;
      end
      checks++;
      if (guard >= 40 || dut.g_bits[5].u_bit.cnt !== 2'd2) begin
         errors++;
         $display("FAIL midcount_setup: got cnt=%0d guard=%0d, expected cnt=2", dut.g_bits[5].u_bit.cnt, guard);
      end
      RESETn = 1'b0;
      #1;
      checks++;
      if ({SW_OUT, SW_RISE, SW_FALL, SW_CHANGED} !== '0 || dut.g_bits[5].u_bit.cnt !== 2'd0) begin
         errors++;
         $display("FAIL midcount_reset: got out=%h rise=%h fall=%h chg=%b cnt=%0d, expected all 0",
                  SW_OUT, SW_RISE, SW_FALL, SW_CHANGED, dut.g_bits[5].u_bit.cnt);
      end
      @(negedge CLK);
      RESETn = 1'b1;
      for (int j = 1; j <= 20; j++) begin
         @(negedge CLK);
         checks++;
         if ({SW_OUT, SW_RISE, SW_FALL, SW_CHANGED} !== {m_out, m_rise, m_fall, m_chg}) begin
            errors++;
            $display("FAIL midcount_model: got out=%h rise=%h fall=%h chg=%b, expected out=%h rise=%h fall=%h chg=%b",
                     SW_OUT, SW_RISE, SW_FALL, SW_CHANGED, m_out, m_rise, m_fall, m_chg);
         end
         if (first < 0 && SW_OUT != '0) first = j;
         if (first < 0 && (SW_RISE != '0 || SW_FALL != '0 || SW_CHANGED)) early = 1'b1;
      end
      checks++;
      if (first - 1 < 10 || first - 1 > 13 || early) begin
         errors++;
         $display("FAIL midcount_latency: got %0d edges early_strobe=%b, expected 10..13 and none", first - 1, early);
      end
   endtask

   task automatic test_glitch();
      int   guard = 0;
      logic bad = 1'b0;
      while ((n_edge + 2) % TD != 0 && guard < 8) begin
         @(negedge CLK);
         guard++;
      end
      SW_IN[15] = 1'b0;
      @(negedge CLK);
      SW_IN[15] = 1'b1;
      for (int j = 1; j <= 12; j++) begin
         @(negedge CLK);
         if (j == 2) begin
            checks++;
            if (dut.g_bits[15].u_bit.cnt !== 2'd1) begin
               errors++;
               $display("FAIL glitch_on_tick: got cnt=%0d, expected 1", dut.g_bits[15].u_bit.cnt);
            end
         end
         if (!SW_OUT[15] || SW_RISE != '0 || SW_FALL != '0 || SW_CHANGED) bad = 1'b1;
      end
      checks++;
      if (bad || dut.g_bits[15].u_bit.cnt !== 2'd0) begin
         errors++;
         $display("FAIL glitch_ignored: got activity=%b cnt=%0d, expected 0 and 0", bad, dut.g_bits[15].u_bit.cnt);
      end
   endtask

   task automatic test_random();
      for (int j = 0; j < 800; j++) begin
         @(negedge CLK);
         checks++;
         if ({SW_OUT, SW_RISE, SW_FALL, SW_CHANGED} !== {m_out, m_rise, m_fall, m_chg}) begin
            errors++;
            $display("FAIL random_model: got out=%h rise=%h fall=%h chg=%b, expected out=%h rise=%h fall=%h chg=%b",
                     SW_OUT, SW_RISE, SW_FALL, SW_CHANGED, m_out, m_rise, m_fall, m_chg);
         end
         if ($urandom_range(7) == 0) SW_IN[$urandom_range(NSW - 1)] ^= 1'b1;
         if ($urandom_range(63) == 0) SW_IN = NSW'($urandom);
      end
   endtask

   initial begin
      test_reset();
      test_clean_step();
      test_bounce();
      test_simultaneous();
      test_reset_mid_count();
      test_glitch();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
